// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART definitions (state encoding and default timing)
//               used by both the transmitter and the receiver.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  // Frame state encoding shared by transmitter and receiver
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  // 100 MHz system clock at 115200 baud
  localparam int unsigned c_default_clks_per_bit = 868;
  localparam int unsigned c_default_data_bits    = 8;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_baud_gen.sv
`default_nettype none
// ============================================================================
// Module      : uart_baud_gen
// Description : Bit-period counter. Counts 0..CLKS_PER_BIT-1 and wraps; tick
//               marks the last cycle of each bit period. clear restarts the
//               period so a newly accepted frame gets a full-length start bit.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = c_default_clks_per_bit
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int unsigned          c_cnt_w = $clog2(CLKS_PER_BIT + 1);
  localparam logic [c_cnt_w-1:0]   c_last  = c_cnt_w'(CLKS_PER_BIT - 1);

  logic [c_cnt_w-1:0] cnt_q;
  logic [c_cnt_w-1:0] cnt_d;

  // Tick is decoded from the registered count only
  assign tick = (cnt_q == c_last);

  // Next count: restart on clear or at the end of a bit period
  always_comb begin
    cnt_d = cnt_q + c_cnt_w'(1);
    if (clear || tick) begin
      cnt_d = '0;
    end
  end

  // Count register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule : uart_baud_gen
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx
// Description : UART transmitter. One start bit, DATA_BITS data bits LSB
//               first, one stop bit. tx, busy and done are all registered.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = c_default_clks_per_bit,
  parameter int unsigned DATA_BITS    = c_default_data_bits
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [DATA_BITS-1:0] data,
  output logic                 tx,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned        c_idx_w    = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(DATA_BITS - 1);

  uart_state_t          state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [c_idx_w-1:0]   idx_q,   idx_d;
  logic                 tx_q,    tx_d;
  logic                 busy_q,  busy_d;
  logic                 done_q,  done_d;

  logic                 w_tick;
  logic                 w_accept;

  // A request is only honoured in IDLE (including the done cycle)
  assign w_accept = (state_q == IDLE) && start;

  uart_baud_gen #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud_gen (
    .clk   (clk),
    .rst   (rst),
    .clear (w_accept),
    .tick  (w_tick)
  );

  // Next-state and next-output logic; the shift register always holds the
  // bits still to be sent, so tx takes shift_q[0] at each data bit boundary
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (start) begin
          shift_d = data;
          state_d = START;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
        end
      end
      START: begin
        if (w_tick) begin
          state_d = DATA;
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
          idx_d   = '0;
        end
      end
      DATA: begin
        if (w_tick) begin
          if (idx_q == c_last_idx) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            idx_d   = idx_q + c_idx_w'(1);
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
          end
        end
      end
      STOP: begin
        if (w_tick) begin
          state_d = IDLE;
          tx_d    = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset wins over any start request
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule : uart_tx
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx
// Description : Randomised scoreboard bench for uart_tx. A frame-level model
//               predicts the line waveform and the frames to be received; a
//               monitor decodes tx like a receiver and checks each done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx;

  localparam int N    = 4;
  localparam int D    = 8;
  localparam int L    = N * (D + 2);
  localparam int MAXC = 4096;

  typedef struct {
    logic [7:0] d;
    int         done_cyc;
  } frame_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] data;
  logic       tx, busy, done;
  logic       start1;
  logic [7:0] data1;
  logic       tx1, busy1, done1;

  uart_tx #(.CLKS_PER_BIT(N), .DATA_BITS(D)) dut (
    .clk(clk), .rst(rst), .start(start), .data(data),
    .tx(tx), .busy(busy), .done(done)
  );

  uart_tx #(.CLKS_PER_BIT(1), .DATA_BITS(D)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .data(data1),
    .tx(tx1), .busy(busy1), .done(done1)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected line waveform, indexed by cycle number
  bit     exp_tx   [MAXC];
  bit     exp_busy [MAXC];
  bit     exp_done [MAXC];
  frame_t sb_q[$];
  int     idle_from;
  int     checks = 0;
  int     errors = 0;
  bit     acc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, expv);
    end
  endtask

  // Apply one cycle of stimulus and update the model with its effect
  task automatic step(input bit s, input logic [7:0] d, input bit r, output bit accepted);
    int n;
    int b;
    n        = cyc;
    start    = s;
    data     = d;
    rst      = r;
    accepted = 1'b0;
    if (r) begin
      for (int c = n + 1; c < MAXC; c++) begin
        exp_tx[c]   = 1'b1;
        exp_busy[c] = 1'b0;
        exp_done[c] = 1'b0;
      end
      if (sb_q.size() > 0 && sb_q[$].done_cyc > n) void'(sb_q.pop_back());
      idle_from = n + 1;
    end else if (s && n >= idle_from) begin
      accepted = 1'b1;
      for (int i = 0; i < L; i++) begin
        b = i / N;
        exp_tx[n + 1 + i]   = (b == 0) ? 1'b0 : (b <= D) ? d[b - 1] : 1'b1;
        exp_busy[n + 1 + i] = 1'b1;
      end
      exp_done[n + 1 + L] = 1'b1;
      sb_q.push_back('{d, n + 1 + L});
      idle_from = n + 1 + L;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int cycles);
    bit a;
    for (int i = 0; i < cycles; i++) step(1'b0, 8'($urandom), 1'b0, a);
  endtask

  // Monitor: per-cycle waveform check plus a receiver that decodes tx
  int         rx_t0;
  bit         rx_act = 1'b0;
  bit         rx_ok  = 1'b0;
  logic [9:0] rx_bits;
  logic [7:0] rx_byte;
  frame_t     f;
  int         k;

  always @(negedge clk) begin
    if (cyc >= 1 && cyc < MAXC) begin
      chk("tx_wave", tx, exp_tx[cyc]);
      chk("busy_wave", busy, exp_busy[cyc]);
      chk("done_wave", done, exp_done[cyc]);
      if (rx_act) begin
        if ((cyc - rx_t0) % N == N / 2) begin
          k = (cyc - rx_t0) / N;
          rx_bits[k] = tx;
          if (k == 9) begin
            rx_act  = 1'b0;
            rx_ok   = 1'b1;
            rx_byte = rx_bits[8:1];
          end
        end
      end else if (tx === 1'b0) begin
        rx_act = 1'b1;
        rx_t0  = cyc;
        rx_ok  = 1'b0;
      end
      if (done === 1'b1) begin
        if (sb_q.size() == 0) begin
          chk("done_unexpected", 1, 0);
        end else begin
          f = sb_q.pop_front();
          chk("frame_decoded", rx_ok, 1);
          chk("frame_byte", rx_byte, f.d);
          chk("frame_start_stop", {rx_bits[9], rx_bits[0]}, 2'b10);
          chk("done_cycle", cyc, f.done_cyc);
          rx_ok = 1'b0;
        end
      end
      if (rst === 1'b1) rx_act = 1'b0;
    end
  end

  initial begin
    int  guard;
    bit  s;
    bit  r;
    logic [7:0] v;
    for (int c = 0; c < MAXC; c++) begin
      exp_tx[c]   = 1'b1;
      exp_busy[c] = 1'b0;
      exp_done[c] = 1'b0;
    end
    idle_from = 0;
    start1    = 1'b0;
    data1     = 8'h00;
    repeat (3) step(1'b0, 8'h00, 1'b1, acc);
    idle(2);

    // Single frame, alternating bits
    step(1'b1, 8'h55, 1'b0, acc);
    idle(50);

    // Asymmetric byte
    step(1'b1, 8'hA3, 1'b0, acc);
    idle(45);

    // Start while busy must be dropped
    step(1'b1, 8'h0F, 1'b0, acc);
    repeat (9) step(1'b0, 8'h0F, 1'b0, acc);
    step(1'b1, 8'hFF, 1'b0, acc);
    idle(40);

    // Back-to-back with start held high
    step(1'b1, 8'h12, 1'b0, acc);
    guard = 0;
    do begin
      step(1'b1, 8'h34, 1'b0, acc);
      guard++;
    end while (!acc && guard < 60);
    idle(45);

    // Reset mid-frame, then a clean frame
    step(1'b1, 8'h00, 1'b0, acc);
    repeat (16) step(1'b0, 8'h00, 1'b0, acc);
    step(1'b0, 8'h00, 1'b1, acc);
    idle(3);
    step(1'b1, 8'hC5, 1'b0, acc);
    idle(45);

    // Reset and start together: reset wins
    step(1'b1, 8'h99, 1'b1, acc);
    idle(3);

    // Random traffic with occasional resets and data changing every cycle
    for (int i = 0; i < 1200; i++) begin
      s = ($urandom_range(0, 3) == 0);
      r = ($urandom_range(0, 199) == 0);
      v = 8'($urandom);
      step(s, v, r, acc);
    end
    idle(50);

    // One-cycle bit period
    start1 = 1'b1;
    data1  = 8'h81;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    data1  = 8'h00;
    v      = 8'h81;
    for (int b = 0; b < 10; b++) begin
      @(negedge clk);
      chk("tx_cpb1", tx1, (b == 0) ? 1'b0 : (b <= 8) ? v[b - 1] : 1'b1);
      chk("busy_cpb1", busy1, 1'b1);
      chk("done_cpb1_low", done1, 1'b0);
    end
    @(negedge clk);
    chk("done_cpb1", done1, 1'b1);
    chk("busy_cpb1_end", busy1, 1'b0);
    chk("tx_cpb1_end", tx1, 1'b1);
    @(posedge clk);
    #1;

    chk("sb_empty", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_uart_tx
`default_nettype wire
